// File: rtl/fill_and_pressurize.sv
// Airlock fill-and-pressurize sequencer: arms on request, fills once both doors close,
// holds at pressure and vents on request, breach or (with FANDP_TIMEOUT_EN) fill timeout.
module fill_and_pressurize #(
   parameter int FILL_TIMEOUT = 8
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       begin_FandP,
   input  logic       InnerClosed,
   input  logic       OuterClosed,
   input  logic       Pressurized,
   input  logic       Evacuated,
   output logic       FandP,
   output logic       Evacuate,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      FILL  = 3'd2,
      HOLD  = 3'd3,
      EVAC  = 3'd4
   } state_t;

   state_t state;
   state_t next_state;
   logic   closed;
   logic   timeout_hit;

   assign closed    = InnerClosed & OuterClosed;
   assign fsm_state = state;

`ifdef FANDP_TIMEOUT_EN
   // Counts cycles already spent in FILL; zero on the first FILL cycle.
   logic [7:0] fill_count;

   always_ff @(posedge Clock) begin
      if (Reset || state != FILL) begin
         fill_count <= '0;
      end else begin
         fill_count <= fill_count + 8'd1;
      end
   end

   assign timeout_hit = (fill_count == 8'(FILL_TIMEOUT - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (begin_FandP) begin
               next_state = closed ? FILL : ARMED;
            end
         end
         ARMED: begin
            if (closed) begin
               next_state = FILL;
            end
         end
         // Breach outranks Pressurized, which outranks the timeout.
         FILL: begin
            if (!closed) begin
               next_state = EVAC;
            end else if (Pressurized) begin
               next_state = HOLD;
            end else if (timeout_hit) begin
               next_state = EVAC;
            end
         end
         HOLD: begin
            if (!closed || begin_FandP) begin
               next_state = EVAC;
            end
         end
         EVAC: begin
            if (Evacuated) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they track the state register exactly.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         FandP    <= 1'b0;
         Evacuate <= 1'b0;
      end else begin
         state    <= next_state;
         FandP    <= (next_state == FILL);
         Evacuate <= (next_state == EVAC);
      end
   end

   always @(posedge Clock) begin
      assert (!(FandP && Evacuate) && FILL_TIMEOUT >= 2 && FILL_TIMEOUT <= 255);
   end

endmodule

// File: tb/tb_fill_and_pressurize.sv
// Self-checking bench for fill_and_pressurize: directed scenarios plus a randomized run
// compared each cycle against a phase-based airlock model.
module tb_fill_and_pressurize;

   localparam int T = 8;
`ifdef FANDP_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       begin_FandP = 1'b0;
   logic       InnerClosed = 1'b0;
   logic       OuterClosed = 1'b0;
   logic       Pressurized = 1'b0;
   logic       Evacuated = 1'b0;
   logic       FandP;
   logic       Evacuate;
   logic [2:0] fsm_state;

   int checks = 0;
   int errors = 0;

   // Model: which phase the airlock is in, and how long it has been filling.
   bit m_armed, m_fill, m_hold, m_evac;
   int m_fill_cycles;

   fill_and_pressurize #(.FILL_TIMEOUT(T)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .begin_FandP(begin_FandP),
      .InnerClosed(InnerClosed),
      .OuterClosed(OuterClosed),
      .Pressurized(Pressurized),
      .Evacuated(Evacuated),
      .FandP(FandP),
      .Evacuate(Evacuate),
      .fsm_state(fsm_state)
   );

   always #5 Clock = ~Clock;

   task automatic model_step();
      bit doors_shut;
      doors_shut = InnerClosed && OuterClosed;
      if (Reset) begin
         m_armed = 0; m_fill = 0; m_hold = 0; m_evac = 0; m_fill_cycles = 0;
      end else if (m_evac) begin
         if (Evacuated) m_evac = 0;
      end else if (m_fill) begin
         m_fill_cycles = m_fill_cycles + 1;
         if (!doors_shut) begin
            m_fill = 0; m_evac = 1;
         end else if (Pressurized) begin
            m_fill = 0; m_hold = 1;
         end else if (TO_EN && m_fill_cycles >= T) begin
            m_fill = 0; m_evac = 1;
         end
      end else if (m_hold) begin
         if (!doors_shut || begin_FandP) begin
            m_hold = 0; m_evac = 1;
         end
      end else if (m_armed) begin
         if (doors_shut) begin
            m_armed = 0; m_fill = 1; m_fill_cycles = 0;
         end
      end else if (begin_FandP) begin
         if (doors_shut) begin
            m_fill = 1; m_fill_cycles = 0;
         end else begin
            m_armed = 1;
         end
      end
   endtask

   // Apply inputs away from the edge, advance one clock, then settle before sampling.
   task automatic cycle(input logic r, input logic b, input logic ic, input logic oc,
                        input logic p, input logic ev);
      @(negedge Clock);
      Reset = r; begin_FandP = b; InnerClosed = ic; OuterClosed = oc;
      Pressurized = p; Evacuated = ev;
      @(posedge Clock);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         cycle(1, 1, 1, 1, 1, 1);
         checks++;
         if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold[%0d]: FandP=%b Evacuate=%b expected 0 0", i, FandP, Evacuate);
         end
      end
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 1, 0, 0);
         checks++;
         if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle[%0d]: FandP=%b Evacuate=%b expected 0 0", i, FandP, Evacuate);
         end
      end
   endtask

   task automatic test_fill_hold_evac();
      cycle(0, 1, 1, 1, 0, 0);
      checks++;
      if (FandP !== 1'b1) begin
         errors++;
         $display("FAIL fill_start: FandP=%b expected 1", FandP);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(0, 0, 1, 1, 0, 0);
         checks++;
         if (FandP !== 1'b1 || Evacuate !== 1'b0) begin
            errors++;
            $display("FAIL fill_run[%0d]: FandP=%b Evacuate=%b expected 1 0", i, FandP, Evacuate);
         end
      end
      cycle(0, 0, 1, 1, 1, 0);
      checks++;
      if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
         errors++;
         $display("FAIL hold_enter: FandP=%b Evacuate=%b expected 0 0", FandP, Evacuate);
      end
      // Pressure loss in HOLD must not disturb it.
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 1, 1, 0, 0);
         checks++;
         if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
            errors++;
            $display("FAIL hold_stay[%0d]: FandP=%b Evacuate=%b expected 0 0", i, FandP, Evacuate);
         end
      end
      cycle(0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (FandP !== 1'b0 || Evacuate !== 1'b1) begin
            errors++;
            $display("FAIL evac_run[%0d]: FandP=%b Evacuate=%b expected 0 1", i, FandP, Evacuate);
         end
         cycle(0, i[0], i[1], 1'b0, 0, 0);
      end
      cycle(0, 0, 1, 1, 0, 1);
      checks++;
      if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
         errors++;
         $display("FAIL evac_done: FandP=%b Evacuate=%b expected 0 0", FandP, Evacuate);
      end
   endtask

   task automatic test_armed();
      cycle(0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
            errors++;
            $display("FAIL armed_wait[%0d]: FandP=%b Evacuate=%b expected 0 0", i, FandP, Evacuate);
         end
         if (i < 3) cycle(0, 0, 1, 0, 0, 0);
      end
      cycle(0, 0, 1, 1, 0, 0);
      checks++;
      if (FandP !== 1'b1) begin
         errors++;
         $display("FAIL armed_fill: FandP=%b expected 1", FandP);
      end
      cycle(0, 0, 1, 1, 1, 0);
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 0, 1);
      checks++;
      if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
         errors++;
         $display("FAIL armed_cleanup: FandP=%b Evacuate=%b expected 0 0", FandP, Evacuate);
      end
   endtask

   task automatic test_breach();
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 0, 0);
      cycle(0, 0, 0, 1, 1, 0);
      checks++;
      if (FandP !== 1'b0 || Evacuate !== 1'b1) begin
         errors++;
         $display("FAIL breach_wins: FandP=%b Evacuate=%b expected 0 1", FandP, Evacuate);
      end
      cycle(0, 0, 1, 1, 0, 1);
   endtask

   task automatic test_timeout();
      int high;
      high = 0;
      cycle(0, 1, 1, 1, 0, 0);
      for (int i = 0; i < 3 * T && FandP === 1'b1; i++) begin
         high++;
         cycle(0, 0, 1, 1, 0, 0);
      end
`ifdef FANDP_TIMEOUT_EN
      checks++;
      if (high != T || Evacuate !== 1'b1) begin
         errors++;
         $display("FAIL timeout_len: FandP high %0d cycles Evacuate=%b, expected %0d then 1", high, Evacuate, T);
      end
`else
      checks++;
      if (high != 3 * T || Evacuate !== 1'b0) begin
         errors++;
         $display("FAIL no_timeout: FandP high %0d cycles Evacuate=%b, expected %0d and 0", high, Evacuate, 3 * T);
      end
      cycle(0, 0, 1, 1, 1, 0);
      cycle(0, 1, 1, 1, 0, 0);
`endif
      cycle(0, 0, 1, 1, 0, 1);
      // Pressurized arriving on the expiry cycle still reaches HOLD.
      cycle(0, 1, 1, 1, 0, 0);
      for (int i = 0; i < T - 1; i++) cycle(0, 0, 1, 1, 0, 0);
      checks++;
      if (FandP !== 1'b1) begin
         errors++;
         $display("FAIL pre_expiry: FandP=%b expected 1", FandP);
      end
      cycle(0, 0, 1, 1, 1, 0);
      checks++;
      if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
         errors++;
         $display("FAIL press_at_expiry: FandP=%b Evacuate=%b expected 0 0", FandP, Evacuate);
      end
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 0, 1, 1, 0, 1);
   endtask

   task automatic test_reset_midflight();
      cycle(0, 1, 1, 1, 0, 0);
      cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 0, 1, 1, 0, 0);
      checks++;
      if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
         errors++;
         $display("FAIL reset_evac: FandP=%b Evacuate=%b expected 0 0", FandP, Evacuate);
      end
      cycle(0, 1, 1, 1, 0, 0);
      checks++;
      if (FandP !== 1'b1) begin
         errors++;
         $display("FAIL reset_idle_fill: FandP=%b expected 1", FandP);
      end
      cycle(1, 1, 1, 1, 1, 1);
      checks++;
      if (FandP !== 1'b0 || Evacuate !== 1'b0) begin
         errors++;
         $display("FAIL reset_fill: FandP=%b Evacuate=%b expected 0 0", FandP, Evacuate);
      end
   endtask

   task automatic test_random();
      logic r, b, ic, oc, p, ev;
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 63) == 0);
         b  = ($urandom_range(0, 3) == 0);
         ic = ($urandom_range(0, 15) != 0);
         oc = ($urandom_range(0, 11) != 0);
         p  = ($urandom_range(0, 9) == 0);
         ev = ($urandom_range(0, 3) == 0);
         cycle(r, b, ic, oc, p, ev);
         checks++;
         if (FandP !== m_fill || Evacuate !== m_evac) begin
            errors++;
            $display("FAIL random[%0d]: FandP=%b Evacuate=%b expected %b %b", n, FandP, Evacuate, m_fill, m_evac);
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_hold_evac();
      test_armed();
      test_breach();
      test_timeout();
      test_reset_midflight();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
